boot_loader: RTL and testbench
==============================

# boot_loader

Program loader that sits directly upstream of the single-cycle RISC-V core. After reset it accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes those words sequentially into the instruction memory's write port starting at word 0. Once the declared number of words is stored, it raises `core_run`, which the top level uses to hold the core's PC/register reset released.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width; capacity is 2**ADDR_W words.
- `TIMEOUT`, 1_000_000: idle cycles allowed between bytes once a load has begun.
- `clk` in 1: system clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `byte_valid` in 1: `byte_data` holds a byte.
- `byte_data` in 8: stream byte.
- `byte_ready` out 1: loader accepts a byte this cycle; a byte transfers when `byte_valid && byte_ready`.
- `imem_we` out 1: one-cycle instruction-memory write strobe.
- `imem_addr` out ADDR_W: word address for the write.
- `imem_wdata` out 32: instruction word for the write.
- `core_run` out 1: load complete, core may execute; level signal.
- `err` out 1: load aborted; level signal.

## Operation
- Stream format: 2-byte word count N, low byte first. Then 4·N instruction bytes, each word least-significant byte first.
- States:
  - `LEN0`: the reset state; accepts the N low byte.
  - `LEN1`: accepts the N high byte. N==0 goes to `DONE`. N>2**ADDR_W goes to `ERR`. Otherwise goes to `DATA`.
  - `DATA`: accepts instruction bytes.
  - `FLUSH`: writes the final word.
  - `DONE`: terminal.
  - `ERR`: terminal.
- In `DATA`, a 2-bit byte index selects the lane: byte k goes into `imem_wdata[8k+7:8k]`. The index wraps 3→0.
- On the 4th byte of a word:
  - Not last word: `imem_we`=1 the next cycle with the current `imem_addr`, then the word counter increments. The loader stays in `DATA` with `byte_ready` high, so a back-to-back stream of one byte per cycle is sustained.
  - Last word (counter == N-1): go to `FLUSH`.
- `FLUSH`: `imem_we`=1 for one cycle, then `DONE`.
- `DONE`: `core_run`=1 and `byte_ready`=0 until reset. Further bytes are ignored.
- `ERR`: `err`=1, `core_run`=0, `byte_ready`=0 until reset.
- Word counter is ADDR_W+1 bits, so N==2**ADDR_W is legal. `imem_addr` is the counter's low ADDR_W bits and never wraps within a load.
- Timeout:
  - An idle counter clears on every accepted byte.
  - In `LEN1` or `DATA`, reaching TIMEOUT cycles without an accepted byte goes to `ERR`.
  - `LEN0` never times out.

## Timing
- Reset values:
  - state `LEN0`
  - `byte_ready`=1
  - `imem_we`=0
  - `imem_addr`=0
  - `imem_wdata`=0
  - `core_run`=0
  - `err`=0
  - all counters 0
- `byte_ready` is 1 exactly in `LEN0`, `LEN1` and `DATA`, and depends only on state (Moore).
- `imem_we` latency: high in the cycle immediately after the handshake of a word's 4th byte. `imem_addr`/`imem_wdata` are stable in that cycle.
- `core_run` rises in the cycle after the `FLUSH` write, i.e. 2 cycles after the last byte handshake. For N==0 it rises 1 cycle after the second length byte.
- `imem_we` and the transfer of byte 0 of the next word may occur in the same cycle. `imem_wdata` for the pending write must be held until the strobe is issued: use a separate assembly register or write lane 0 only after the strobe.
- Reset asserted mid-load: all outputs return to their reset values immediately and asynchronously. Memory contents already written are not cleared. The next load restarts at `LEN0`.
- `byte_valid` low does not advance the byte index or the counters.

## Structure
- Shared package `boot_pkg`: state enum (`LEN0`, `LEN1`, `DATA`, `FLUSH`, `DONE`, `ERR`) and a localparam for the length-field byte count (2).
- Natural sub-module: `word_assembler`, covering the byte index, the lane-shift register and the word-complete pulse. The FSM, counters and timeout stay in `boot_loader`.
- Top-level hookup: the core's reset is the AND of `rst` and `core_run`. The instruction-memory write port is driven by `imem_*`.

## Test plan
- Reset: check every output at its reset value and `byte_ready`=1, with no clock edges.
- Stream 02 00 13 05 50 00 93 05 30 00 with valid held high:
  - first write `addr=0`, `data=0x00500513`
  - second write `addr=1`, `data=0x00300593`
  - `core_run`=1 two cycles after the last byte
  - exactly 2 `imem_we` pulses
- Same stream with random 0–5 cycle `byte_valid` gaps (all below TIMEOUT): identical writes, no `err`.
- Length tests with ADDR_W=8:
  - N=0 (00 00): `core_run`=1 one cycle later, no writes.
  - N=257 (01 01): `err`=1 one cycle after the second byte, `byte_ready`=0.
  - N=256: 256 writes, last at `addr=255`.
- TIMEOUT=16, send 02 00 13 then stall: `err`=1 after 16 idle cycles, `core_run` stays 0, no `imem_we`.
- Assert `rst` low during the 2nd word's third byte: outputs reset asynchronously. Then a fresh 1-word load writes `addr=0` and sets `core_run`.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// boot_pkg: shared definitions for the boot loader slice.
//   boot_state_t : loader FSM states
//   LEN_BYTES    : number of bytes in the little-endian word-count header
package boot_pkg;

   typedef enum logic [2:0] {
      LEN0  = 3'd0,
      LEN1  = 3'd1,
      DATA  = 3'd2,
      FLUSH = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } boot_state_t;

   localparam int LEN_BYTES = 2;

endpackage

// File: rtl/boot_loader_word_assembler.sv
// word_assembler: packs accepted stream bytes into little-endian 32-bit words.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   take            : a DATA byte is transferred this cycle
//   byte_data       : the byte being transferred
//   last_lane       : the next byte taken completes a word (index == 3)
//   word            : completed word, held until the next word completes
//   word_done       : one-cycle pulse in the cycle after a word's 4th byte
module word_assembler
   import boot_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        take,
   input  logic [7:0]  byte_data,
   output logic        last_lane,
   output logic [31:0] word,
   output logic        word_done
);

   logic [1:0]  idx_r;
   logic [23:0] lanes_r;

   assign last_lane = (idx_r == 2'd3);

   // Lanes 0..2 collect in lanes_r; the 4th byte moves the whole word into
   // the output register, so the next word's byte 0 can arrive while the
   // completed word is still being written.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_r     <= 2'd0;
         lanes_r   <= 24'd0;
         word      <= 32'd0;
         word_done <= 1'b0;
      end else begin
         word_done <= 1'b0;
         if (take) begin
            idx_r <= idx_r + 2'd1;
            case (idx_r)
               2'd0:    lanes_r[7:0]   <= byte_data;
               2'd1:    lanes_r[15:8]  <= byte_data;
               2'd2:    lanes_r[23:16] <= byte_data;
               2'd3: begin
                  word      <= {byte_data, lanes_r};
                  word_done <= 1'b1;
               end
               default: lanes_r <= lanes_r;
            endcase
         end
      end
   end

endmodule

// File: rtl/boot_loader.sv
// boot_loader: receives a length-prefixed byte stream and writes the
// assembled instruction words into instruction memory from word 0 upward,
// then raises core_run. The system ANDs rst with core_run to form the
// core's reset.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   byte_valid/byte_data  : stream input; byte_ready is the acceptance side
//   imem_we/addr/wdata    : instruction-memory write port
//   core_run              : load complete (level)
//   err                   : load aborted, bad length or timeout (level)
module boot_loader
   import boot_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 1_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_run,
   output logic              err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   boot_state_t   state_r;
   logic [15:0]   len_r;
   logic [ADDR_W:0] cnt_r;
   logic [TW-1:0] idle_r;

   logic        take_s;
   logic        last_lane_s;
   logic [15:0] n_s;
   logic [15:0] len_m1_s;
   logic        last_word_s;
   logic        timeout_s;

   assign take_s      = byte_valid && byte_ready;
   assign n_s         = {byte_data, len_r[7:0]};
   assign len_m1_s    = len_r - 16'd1;
   assign last_word_s = (32'(cnt_r) == 32'(len_m1_s));
   assign timeout_s   = (idle_r == TW'(TIMEOUT - 1));
   assign imem_addr   = cnt_r[ADDR_W-1:0];

   word_assembler u_asm (
      .clk       (clk),
      .rst       (rst),
      .take      (take_s && (state_r == DATA)),
      .byte_data (byte_data),
      .last_lane (last_lane_s),
      .word      (imem_wdata),
      .word_done (imem_we)
   );

   // Loader FSM with its length, word and idle counters; byte_ready,
   // core_run and err are registered alongside the state they describe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= LEN0;
         len_r      <= 16'd0;
         cnt_r      <= '0;
         idle_r     <= '0;
         byte_ready <= 1'b1;
         core_run   <= 1'b0;
         err        <= 1'b0;
      end else begin
         // Address advances only after the strobe that used it; never in
         // FLUSH so the final address does not wrap for a full memory.
         if (imem_we && (state_r == DATA)) begin
            cnt_r <= cnt_r + 1'b1;
         end
         case (state_r)
            LEN0: begin
               if (take_s) begin
                  len_r[7:0] <= byte_data;
                  idle_r     <= '0;
                  state_r    <= LEN1;
               end
            end
            LEN1: begin
               if (take_s) begin
                  len_r[15:8] <= byte_data;
                  idle_r      <= '0;
                  if (n_s == 16'd0) begin
                     state_r    <= DONE;
                     core_run   <= 1'b1;
                     byte_ready <= 1'b0;
                  end else if (32'(n_s) > (32'd1 << ADDR_W)) begin
                     state_r    <= ERR;
                     err        <= 1'b1;
                     byte_ready <= 1'b0;
                  end else begin
                     state_r <= DATA;
                  end
               end else if (timeout_s) begin
                  state_r    <= ERR;
                  err        <= 1'b1;
                  byte_ready <= 1'b0;
               end else begin
                  idle_r <= idle_r + 1'b1;
               end
            end
            DATA: begin
               if (take_s) begin
                  idle_r <= '0;
                  if (last_lane_s && last_word_s) begin
                     state_r    <= FLUSH;
                     byte_ready <= 1'b0;
                  end
               end else if (timeout_s) begin
                  state_r    <= ERR;
                  err        <= 1'b1;
                  byte_ready <= 1'b0;
               end else begin
                  idle_r <= idle_r + 1'b1;
               end
            end
            FLUSH: begin
               state_r  <= DONE;
               core_run <= 1'b1;
            end
            DONE: begin
               state_r <= DONE;
            end
            ERR: begin
               state_r <= ERR;
            end
            default: begin
               state_r    <= ERR;
               err        <= 1'b1;
               core_run   <= 1'b0;
               byte_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader (ADDR_W=8, TIMEOUT=16).
module tb_boot_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data = 8'h00;
   logic       byte_ready;
   logic       imem_we;
   logic [7:0] imem_addr;
   logic [31:0] imem_wdata;
   logic       core_run;
   logic       err;

   int vec_cnt = 0;
   int miss_cnt = 0;

   int          wr_n = 0;
   logic [7:0]  wr_a [0:299];
   logic [31:0] wr_d [0:299];

   boot_loader #(.ADDR_W(8), .TIMEOUT(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_run   (core_run),
      .err        (err)
   );

   initial begin
      #20;
      forever #5 clk = ~clk;
   end

   // Write log, sampled away from the rising edge.
   always @(negedge clk) begin
      if (imem_we && wr_n < 300) begin
         wr_a[wr_n] = imem_addr;
         wr_d[wr_n] = imem_wdata;
      end
      if (imem_we) wr_n = wr_n + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         miss_cnt++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns at #1 after the handshake edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      byte_valid = 1'b0;
      repeat (gap) tick();
      byte_valid = 1'b1;
      byte_data  = b;
      t = 0;
      while (!byte_ready && t < 50) begin
         tick();
         t++;
      end
      if (!byte_ready) check("ready_wait", 32'(byte_ready), 32'd1);
      tick();
      byte_valid = 1'b0;
   endtask

   task automatic do_reset();
      #2 rst = 1'b0;
      #2 rst = 1'b1;
      wr_n = 0;
   endtask

   logic [7:0] prog [0:9];
   int gaps [0:9];

   initial begin
      prog = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h30, 8'h00};
      gaps = '{0, 3, 1, 5, 2, 0, 4, 1, 5, 2};

      // Reset with no clock edges.
      #2 rst = 1'b0;
      #1;
      check("rst_ready", 32'(byte_ready), 32'd1);
      check("rst_we",    32'(imem_we),    32'd0);
      check("rst_addr",  32'(imem_addr),  32'd0);
      check("rst_wdata", imem_wdata,      32'd0);
      check("rst_run",   32'(core_run),   32'd0);
      check("rst_err",   32'(err),        32'd0);
      #1 rst = 1'b1;
      wr_n = 0;
      tick();

      // Two-word stream, back to back.
      for (int i = 0; i < 10; i++) send_byte(prog[i], 0);
      check("b2b_run_c1", 32'(core_run), 32'd0);
      tick();
      check("b2b_run_c2", 32'(core_run), 32'd1);
      check("b2b_ready",  32'(byte_ready), 32'd0);
      tick(); tick();
      check("b2b_nwr",   32'(wr_n), 32'd2);
      check("b2b_a0",    32'(wr_a[0]), 32'd0);
      check("b2b_d0",    wr_d[0], 32'h00500513);
      check("b2b_a1",    32'(wr_a[1]), 32'd1);
      check("b2b_d1",    wr_d[1], 32'h00300593);
      check("b2b_err",   32'(err), 32'd0);

      // Same stream with gaps.
      do_reset();
      tick();
      for (int i = 0; i < 10; i++) send_byte(prog[i], gaps[i]);
      tick(); tick(); tick();
      check("gap_nwr", 32'(wr_n), 32'd2);
      check("gap_a0",  32'(wr_a[0]), 32'd0);
      check("gap_d0",  wr_d[0], 32'h00500513);
      check("gap_a1",  32'(wr_a[1]), 32'd1);
      check("gap_d1",  wr_d[1], 32'h00300593);
      check("gap_run", 32'(core_run), 32'd1);
      check("gap_err", 32'(err), 32'd0);

      // N = 0.
      do_reset();
      tick();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      check("n0_run",   32'(core_run), 32'd1);
      check("n0_ready", 32'(byte_ready), 32'd0);
      tick(); tick();
      check("n0_nwr",   32'(wr_n), 32'd0);

      // N = 257: too long.
      do_reset();
      tick();
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      check("n257_err",   32'(err), 32'd1);
      check("n257_ready", 32'(byte_ready), 32'd0);
      check("n257_run",   32'(core_run), 32'd0);

      // N = 256: fill the whole memory.
      do_reset();
      tick();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      for (int w = 0; w < 256; w++) begin
         send_byte(8'(w), 0);
         send_byte(8'(w) ^ 8'hA5, 0);
         send_byte(8'h5A, 0);
         send_byte(8'hC3, 0);
      end
      tick(); tick();
      check("n256_nwr", 32'(wr_n), 32'd256);
      check("n256_run", 32'(core_run), 32'd1);
      check("n256_last_a", 32'(wr_a[255]), 32'd255);
      check("n256_last_d", wr_d[255], 32'hC35A5AFF);
      begin
         int bad;
         bad = 0;
         for (int w = 0; w < 256; w++) begin
            if (wr_a[w] !== 8'(w) || wr_d[w] !== {8'hC3, 8'h5A, 8'(w) ^ 8'hA5, 8'(w)}) bad++;
         end
         check("n256_all", 32'(bad), 32'd0);
      end

      // Timeout after 02 00 13.
      do_reset();
      tick();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h13, 0);
      repeat (15) tick();
      check("to_err_15", 32'(err), 32'd0);
      tick();
      check("to_err_16", 32'(err), 32'd1);
      check("to_run",    32'(core_run), 32'd0);
      check("to_ready",  32'(byte_ready), 32'd0);
      check("to_nwr",    32'(wr_n), 32'd0);

      // Asynchronous reset during the 2nd word's third byte.
      do_reset();
      tick();
      for (int i = 0; i < 8; i++) send_byte(prog[i], 0);
      check("ar_addr_pre", 32'(imem_addr), 32'd1);
      byte_valid = 1'b1;
      byte_data  = prog[8];
      #2 rst = 1'b0;
      #1;
      check("ar_ready", 32'(byte_ready), 32'd1);
      check("ar_we",    32'(imem_we), 32'd0);
      check("ar_addr",  32'(imem_addr), 32'd0);
      check("ar_wdata", imem_wdata, 32'd0);
      check("ar_run",   32'(core_run), 32'd0);
      check("ar_err",   32'(err), 32'd0);
      byte_valid = 1'b0;
      #1 rst = 1'b1;
      wr_n = 0;
      tick();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'hEF, 0);
      send_byte(8'hBE, 0);
      send_byte(8'hAD, 0);
      send_byte(8'hDE, 0);
      tick(); tick();
      check("ar2_nwr", 32'(wr_n), 32'd1);
      check("ar2_a0",  32'(wr_a[0]), 32'd0);
      check("ar2_d0",  wr_d[0], 32'hDEADBEEF);
      check("ar2_run", 32'(core_run), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
